// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate under test through all eight input vectors and captures its truth table.
// The gate output is sampled through a synchroniser after a settle interval, then compared with an expected word.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
);

  if ((SYNC_STAGES < 1) || (SYNC_STAGES > 3)) begin : g_bad_sync
    $fatal(1, "truth_table_sweeper: SYNC_STAGES must be 1..3");
  end
  if ((SETTLE_CYCLES < SYNC_STAGES + 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
    $fatal(1, "truth_table_sweeper: SETTLE_CYCLES must be SYNC_STAGES+1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t                 state_r, state_s;
  logic [2:0]             vec_r, vec_s;
  logic [7:0]             cnt_r, cnt_s;
  logic [7:0]             table_r, table_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sample_s;

  assign sample_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain on the gate output; the last stage is what gets captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= gate_out;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Next-state logic; abort takes priority over capture while a sweep is running.
  always_comb begin
    state_s = state_r;
    vec_s   = vec_r;
    cnt_s   = cnt_r;
    table_s = table_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_SETTLE;
          vec_s   = 3'd0;
          cnt_s   = 8'd0;
          table_s = 8'h00;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_s = ST_IDLE;
          vec_s   = 3'd0;
          cnt_s   = 8'd0;
          table_s = 8'h00;
        end else if (cnt_r == SETTLE_LAST) begin
          state_s = ST_CAPTURE;
          cnt_s   = cnt_r + 8'd1;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_s = ST_IDLE;
          vec_s   = 3'd0;
          cnt_s   = 8'd0;
          table_s = 8'h00;
        end else begin
          table_s[vec_r] = sample_s;
          if (vec_r == 3'd7) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SETTLE;
            vec_s   = vec_r + 3'd1;
            cnt_s   = 8'd0;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        vec_s   = 3'd0;
        cnt_s   = 8'd0;
        table_s = 8'h00;
      end
    endcase
    busy_s = (state_s == ST_SETTLE) || (state_s == ST_CAPTURE);
    done_s = (state_s == ST_DONE);
  end

  // State, vector, counter, table and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      vec_r   <= 3'd0;
      cnt_r   <= 8'd0;
      table_r <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      cnt_r   <= cnt_s;
      table_r <= table_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign in1       = vec_r[2];
  assign in2       = vec_r[1];
  assign in3       = vec_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign table_out = table_r;
  // expected is deliberately unregistered so match tracks it while done holds.
  assign match     = done_r && (table_r == expected);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE 4 and 3) checked every cycle against an
// elapsed-time model of the sweep, plus directed latency/table/match checks.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [2];
  logic       abort_v [2];
  logic [7:0] expected_v [2];
  logic [7:0] gate_tbl [2];
  logic       gate_v [2];
  logic       in1_v [2];
  logic       in2_v [2];
  logic       in3_v [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic [7:0] table_v [2];
  logic       match_v [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .expected(expected_v[0]), .gate_out(gate_v[0]),
    .in1(in1_v[0]), .in2(in2_v[0]), .in3(in3_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .table_out(table_v[0]), .match(match_v[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .expected(expected_v[1]), .gate_out(gate_v[1]),
    .in1(in1_v[1]), .in2(in2_v[1]), .in3(in3_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .table_out(table_v[1]), .match(match_v[1])
  );

  // Gate under test: a truth-table lookup indexed by {in1,in2,in3}.
  assign gate_v[0] = gate_tbl[0][{in1_v[0], in2_v[0], in3_v[0]}];
  assign gate_v[1] = gate_tbl[1][{in1_v[1], in2_v[1], in3_v[1]}];

  function automatic int settle_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  // Model: a sweep is just elapsed edges since start; every SETTLE+1 edges one table bit lands.
  bit         m_busy [2];
  bit         m_done [2];
  int         m_n [2];
  logic [7:0] m_tbl [2];
  logic [2:0] m_vec [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_n[i]    <= 0;
        m_tbl[i]  <= 8'h00;
        m_vec[i]  <= 3'd0;
      end else if (!m_busy[i]) begin
        if (start_v[i]) begin
          m_busy[i] <= 1'b1;
          m_done[i] <= 1'b0;
          m_n[i]    <= 0;
          m_tbl[i]  <= 8'h00;
          m_vec[i]  <= 3'd0;
        end
      end else if (abort_v[i]) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_n[i]    <= 0;
        m_tbl[i]  <= 8'h00;
        m_vec[i]  <= 3'd0;
      end else begin
        m_n[i] <= m_n[i] + 1;
        if (((m_n[i] + 1) % (settle_of(i) + 1)) == 0)
          m_tbl[i][3'((m_n[i] + 1) / (settle_of(i) + 1) - 1)] <=
            gate_tbl[i][3'((m_n[i] + 1) / (settle_of(i) + 1) - 1)];
        m_vec[i] <= (((m_n[i] + 1) / (settle_of(i) + 1)) >= 7) ? 3'd7
                    : 3'((m_n[i] + 1) / (settle_of(i) + 1));
        if ((m_n[i] + 1) == 8 * (settle_of(i) + 1)) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs_of(input int i);
    return {19'd0, in1_v[i], in2_v[i], in3_v[i], busy_v[i], done_v[i], table_v[i], match_v[i]};
  endfunction

  // Cycle compare of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "cycle_dut0" : "cycle_dut1", outs_of(i),
            {19'd0, m_vec[i], m_busy[i], m_done[i], m_tbl[i],
             m_done[i] && (m_tbl[i] == expected_v[i])});
    end
  end

  task automatic assert_start(input int i);
    @(negedge clk);
    #1 start_v[i] = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int i);
    assert_start(i);
    #1 start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_v[i] && n < limit);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want $finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    gate_tbl[0] = 8'hFB;
    gate_tbl[1] = 8'h00;
    expected_v[0] = 8'hFB;
    expected_v[1] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_outs", outs_of(0), 32'd0);
    #1 rst_n = 1'b1;

    // 1: FB gate, expected FB; a start pulse mid-sweep must be ignored.
    pulse_start(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 10) #1 start_v[0] = 1'b1;
      if (n == 11) #1 start_v[0] = 1'b0;
    end while (!done_v[0] && n < 100);
    check("t1_latency", n, 32'd40);
    check("t1_table", table_v[0], 32'hFB);
    check("t1_match", match_v[0], 32'd1);

    // 2: expected changed in DONE, match follows combinationally.
    #1 expected_v[0] = 8'hFF;
    #1;
    check("t2_match", match_v[0], 32'd0);
    check("t2_done", done_v[0], 32'd1);
    check("t2_table", table_v[0], 32'hFB);
    expected_v[0] = 8'hFB;

    // 3: gate tied low on the SETTLE=3 instance, then a re-sweep.
    pulse_start(1);
    wait_done(1, 100, n);
    check("t3_latency", n, 32'd32);
    check("t3_table", table_v[1], 32'h00);
    pulse_start(1);
    check("t3_done_drop", done_v[1], 32'd0);
    check("t3_busy_rise", busy_v[1], 32'd1);
    wait_done(1, 100, n);
    check("t3_latency2", n, 32'd32);

    // 4: abort while vector 4 is applied.
    pulse_start(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ({in1_v[0], in2_v[0], in3_v[0]} != 3'b100 && n < 60);
    check("t4_reach_vec4", {in1_v[0], in2_v[0], in3_v[0]}, 32'd4);
    #1 abort_v[0] = 1'b1;
    @(negedge clk);
    check("t4_busy", busy_v[0], 32'd0);
    check("t4_table", table_v[0], 32'h00);
    check("t4_vec", {in1_v[0], in2_v[0], in3_v[0]}, 32'd0);
    #1 abort_v[0] = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    check("t4_no_done", seen, 32'd0);

    // 5: asynchronous reset between edges mid-sweep.
    pulse_start(0);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_dut0", outs_of(0), 32'd0);
    check("t5_async_dut1", outs_of(1), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    pulse_start(0);
    wait_done(0, 100, n);
    check("t5_latency", n, 32'd40);
    check("t5_table", table_v[0], 32'hFB);
    check("t5_match", match_v[0], 32'd1);

    // 6: start held high, done pulses once every 41 cycles.
    assert_start(0);
    wait_done(0, 100, n);
    check("t6_first", n, 32'd40);
    check("t6_table1", table_v[0], 32'hFB);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      check("t6_done_width", done_v[0], 32'd0);
      wait_done(0, 100, n);
      check("t6_period", n + 1, 32'd41);
      check("t6_table", table_v[0], 32'hFB);
    end
    #1 start_v[0] = 1'b0;
    wait_done(0, 100, n);
    check("t6_final_table", table_v[0], 32'hFB);
    repeat (3) @(negedge clk);
    check("t6_done_hold", done_v[0], 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
